himax_frame_pingpong_ctrl: RTL and testbench
============================================

Name: himax_frame_pingpong_ctrl

Overview:
- Sits directly downstream of the Himax video-process stage, in the `clk` domain, between that stage and the ML engine.
- Owns the `i_rd_rdy`/`o_rd_done` handshake with the video process and steers its write stream (we/waddr/dout) into one of two frame banks of the ML input memory.
- Validates the word count of each frame and hands completed frames to the ML engine in fill order through a valid/ready handshake.
- Frees a bank when the ML engine reports it has finished with it.

Parameters:
- EXP_WORDS, 12288: words a good frame must contain (3 channels x 64 x 64).
- AW, 16: width of the upstream write address.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous reset, active-high.
- i_vp_we  in  1  write strobe from the video process.
- i_vp_waddr  in  AW  write address from the video process.
- i_vp_dout  in  16  write data from the video process.
- i_vp_rd_done  in  1  frame-complete level from the video process; stays high until rd_rdy drops or vsync.
- o_vp_rd_rdy  out  1  tells the video process a bank is armed for filling.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW+1  memory address = {bank, waddr}.
- o_mem_wdata  out  16  memory write data.
- o_frame_vld  out  1  a full bank is available to the ML engine.
- o_frame_bank  out  1  index of the offered bank.
- i_frame_rdy  in  1  ML engine accepts the offered bank.
- i_ml_done  in  1  one-cycle pulse: ML engine has released its busy bank.
- o_frame_err  out  1  one-cycle pulse: a frame was dropped for a bad word count.
- o_err_sticky  out  1  set by any frame error; cleared only by reset.
- o_drop_cnt  out  8  count of dropped frames; saturates at 255.

Behaviour:
- Reset values: all outputs 0; both banks FREE; fill FSM in IDLE; the "older" pointer = 0.
- Bank states, one per bank: FREE, FILL, FULL, BUSY.
  - At most one bank is in FILL at a time.
  - At most one bank is in BUSY at a time.
- Fill FSM:
  - IDLE: if any bank is FREE, pick the lowest-index FREE bank as wbank, mark it FILL, clear word_cnt, go to ARM. Otherwise stay in IDLE with o_vp_rd_rdy=0, so upstream skips frames.
  - ARM: o_vp_rd_rdy=1 (registered, asserted the cycle after entry). Each i_vp_we increments word_cnt (16 bits, saturating at 0xFFFF).
  - Rising edge of i_vp_rd_done (registered edge detect, so a level held high counts once) ends the fill:
    - o_vp_rd_rdy <= 0 and the FSM returns to IDLE.
    - word_cnt == EXP_WORDS: bank -> FULL; if the other bank is FULL it stays older, otherwise the new bank becomes older.
    - Otherwise: bank -> FREE, o_frame_err pulses, o_err_sticky <= 1, o_drop_cnt increments.
  - A new bank cannot be armed in the same cycle a fill completes; IDLE is always traversed for at least 1 cycle.
- Write path:
  - Latency is 1 cycle, all outputs registered.
  - When i_vp_we=1 and FSM=ARM: o_mem_we=1, o_mem_addr={wbank,i_vp_waddr}, o_mem_wdata=i_vp_dout.
  - i_vp_we outside ARM is dropped: o_mem_we stays 0 and word_cnt is unchanged.
  - The word count includes the write that lands in the same cycle as the rd_done edge.
- ML handshake:
  - o_frame_vld=1 when at least one bank is FULL and no bank is BUSY.
  - o_frame_bank = the older FULL bank, or the only FULL bank.
  - Both signals are combinational from registered state and hold stable until accepted.
  - Accept (vld & rdy): the bank goes BUSY next cycle; the older pointer moves to the remaining FULL bank, if any.
  - i_ml_done: the BUSY bank -> FREE. i_ml_done with no BUSY bank is ignored.
- Simultaneous events:
  - i_ml_done and a fill completion in the same cycle: both are applied.
  - i_ml_done and accept in the same cycle are impossible, because vld requires no BUSY bank.
  - A freed bank is eligible in IDLE on the following cycle.
- Reset mid-fill or mid-ML: everything returns to reset state; in-flight writes after reset are dropped until the next ARM.

Test Plan:
- Single frame: reset, then 12288 writes at addr 0..12287 in ARM, then raise rd_done.
  - Required: o_mem_addr = 0x0000..0x2FFF (bank 0).
  - Required: o_frame_vld=1 with bank=0 two cycles after the rd_done edge.
  - Required: rd_rdy re-asserts for bank 1.
- Short frame: 12287 writes then rd_done.
  - Required: o_frame_err pulses once, o_drop_cnt=1, o_err_sticky=1.
  - Required: bank 0 is re-armed and o_frame_vld stays 0.
- Both full, ML stalled: two good frames with i_frame_rdy=0.
  - Required: o_vp_rd_rdy=0, writes are dropped (o_mem_we=0).
  - Then frame_rdy: bank 0 is offered first, then bank 1 after i_ml_done.
- Level rd_done: hold i_vp_rd_done high for 50 cycles.
  - Required: exactly one fill completion; the next ARM waits for a new rising edge.
- Simultaneous: i_ml_done in the same cycle as the rd_done edge of the other bank.
  - Required: the freed bank is armed next, and the completed bank is offered with vld=1.
- Reset asserted mid-fill after 500 writes.
  - Required: all outputs 0, and the next frame fills bank 0 from word_cnt=0.

Source files
------------

// File: rtl/himax_frame_pingpong_ctrl_if.sv
// Handshake and bus bundle between the Himax video process, the ping-pong
// controller and the ML engine.
interface himax_frame_pingpong_ctrl_if #(
    parameter int unsigned AW = 16
);
    logic          i_vp_we;
    logic [AW-1:0] i_vp_waddr;
    logic [15:0]   i_vp_dout;
    logic          i_vp_rd_done;
    logic          o_vp_rd_rdy;
    logic          o_mem_we;
    logic [AW:0]   o_mem_addr;
    logic [15:0]   o_mem_wdata;
    logic          o_frame_vld;
    logic          o_frame_bank;
    logic          i_frame_rdy;
    logic          i_ml_done;
    logic          o_frame_err;
    logic          o_err_sticky;
    logic [7:0]    o_drop_cnt;

    modport master (
        output i_vp_we, i_vp_waddr, i_vp_dout, i_vp_rd_done, i_frame_rdy, i_ml_done,
        input  o_vp_rd_rdy, o_mem_we, o_mem_addr, o_mem_wdata, o_frame_vld, o_frame_bank,
        input  o_frame_err, o_err_sticky, o_drop_cnt
    );

    modport slave (
        input  i_vp_we, i_vp_waddr, i_vp_dout, i_vp_rd_done, i_frame_rdy, i_ml_done,
        output o_vp_rd_rdy, o_mem_we, o_mem_addr, o_mem_wdata, o_frame_vld, o_frame_bank,
        output o_frame_err, o_err_sticky, o_drop_cnt
    );
endinterface

// File: rtl/himax_frame_pingpong_ctrl.sv
// Two-bank ping-pong controller: fills banks from the video process, validates
// the word count and offers completed frames to the ML engine in fill order.
module himax_frame_pingpong_ctrl #(
    parameter int unsigned EXP_WORDS = 12288,
    parameter int unsigned AW        = 16
) (
    input logic                       clk,
    input logic                       reset,
    himax_frame_pingpong_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BkFree, BkFill, BkFull, BkBusy} bank_st_e;
    typedef enum logic {StIdle, StArm} fill_st_e;

    bank_st_e    bank_q [2];
    fill_st_e    fill_q;
    logic        wbank_q;
    logic        older_q;
    logic [15:0] word_cnt_q;
    logic        rd_done_q1, rd_done_q2;
    logic        rd_rdy_q;
    logic        mem_we_q;
    logic [AW:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        frame_err_q;
    logic        err_sticky_q;
    logic [7:0]  drop_cnt_q;

    logic [1:0]  is_free, is_full, is_busy;
    logic        any_busy, busy_bank, free_bank;
    logic        frame_vld, frame_bank, accept;
    logic        we_ok, complete, good, other_full_kept;
    logic [15:0] cnt_next;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            is_free[i] = (bank_q[i] == BkFree);
            is_full[i] = (bank_q[i] == BkFull);
            is_busy[i] = (bank_q[i] == BkBusy);
        end
        any_busy   = |is_busy;
        busy_bank  = is_busy[1];
        free_bank  = ~is_free[0];
        frame_vld  = (|is_full) & ~any_busy;
        // With both banks full the older one goes first.
        frame_bank = (&is_full) ? older_q : is_full[1];
        accept     = frame_vld & bus.i_frame_rdy;
        we_ok      = (fill_q == StArm) & bus.i_vp_we;
        complete   = (fill_q == StArm) & rd_done_q1 & ~rd_done_q2;
        cnt_next   = (we_ok && word_cnt_q != 16'hFFFF) ? word_cnt_q + 16'd1 : word_cnt_q;
        good       = (cnt_next == 16'(EXP_WORDS));
        other_full_kept = is_full[~wbank_q] & ~(accept & (frame_bank == ~wbank_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]    <= BkFree;
            bank_q[1]    <= BkFree;
            fill_q       <= StIdle;
            wbank_q      <= 1'b0;
            older_q      <= 1'b0;
            word_cnt_q   <= 16'd0;
            rd_done_q1   <= 1'b0;
            rd_done_q2   <= 1'b0;
            rd_rdy_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'd0;
            frame_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            rd_done_q1  <= bus.i_vp_rd_done;
            rd_done_q2  <= rd_done_q1;
            mem_we_q    <= we_ok;
            frame_err_q <= 1'b0;
            if (we_ok) begin
                mem_addr_q  <= {wbank_q, bus.i_vp_waddr};
                mem_wdata_q <= bus.i_vp_dout;
            end

            if (accept) begin
                bank_q[frame_bank] <= BkBusy;
                older_q            <= ~frame_bank;
            end
            if (bus.i_ml_done && any_busy) begin
                bank_q[busy_bank] <= BkFree;
            end

            case (fill_q)
                StIdle: begin
                    rd_rdy_q <= 1'b0;
                    if (|is_free) begin
                        wbank_q           <= free_bank;
                        bank_q[free_bank] <= BkFill;
                        word_cnt_q        <= 16'd0;
                        fill_q            <= StArm;
                    end
                end
                StArm: begin
                    word_cnt_q <= cnt_next;
                    rd_rdy_q   <= 1'b1;
                    if (complete) begin
                        rd_rdy_q <= 1'b0;
                        fill_q   <= StIdle;
                        if (good) begin
                            bank_q[wbank_q] <= BkFull;
                            if (!other_full_kept) begin
                                older_q <= wbank_q;
                            end
                        end else begin
                            bank_q[wbank_q] <= BkFree;
                            frame_err_q     <= 1'b1;
                            err_sticky_q    <= 1'b1;
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                default: fill_q <= StIdle;
            endcase
        end
    end

    assign bus.o_vp_rd_rdy  = rd_rdy_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_wdata  = mem_wdata_q;
    assign bus.o_frame_vld  = frame_vld;
    assign bus.o_frame_bank = frame_bank;
    assign bus.o_frame_err  = frame_err_q;
    assign bus.o_err_sticky = err_sticky_q;
    assign bus.o_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_himax_frame_pingpong_ctrl.sv
// Scoreboard bench for the ping-pong controller: memory writes and offered
// banks are queued as stimulus is driven and popped as the DUT produces them.
module tb_himax_frame_pingpong_ctrl;
    localparam int unsigned AW  = 16;
    localparam int unsigned EXP = 12288;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    himax_frame_pingpong_ctrl_if #(.AW(AW)) bus ();

    himax_frame_pingpong_ctrl #(.EXP_WORDS(EXP), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [AW+16:0] wq [$];
    logic           fq [$];

    // One clock: sample outputs of the previous edge at negedge, then advance.
    task automatic step();
        logic [AW+16:0] e;
        logic           b;
        @(negedge clk);
        if (bus.o_frame_err === 1'b1) err_pulses++;
        if (bus.o_mem_we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus.o_mem_addr, bus.o_mem_wdata);
            end else begin
                e = wq.pop_front();
                if ({bus.o_mem_addr, bus.o_mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                             bus.o_mem_addr, bus.o_mem_wdata, e[AW+16:16], e[15:0]);
                end
            end
        end
        if (bus.o_frame_vld === 1'b1 && bus.i_frame_rdy === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_accept: got bank=%0d, required no offer",
                         bus.o_frame_bank);
            end else begin
                b = fq.pop_front();
                if (bus.o_frame_bank !== b) begin
                    errors++;
                    $display("FAIL offer_order: got bank=%0d, required bank=%0d",
                             bus.o_frame_bank, b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int first, input int n, input logic bank, input bit exp);
        logic [15:0] a, d;
        for (int i = first; i < first + n; i++) begin
            a = 16'(i);
            d = a ^ 16'h5A5A;
            bus.i_vp_we    = 1'b1;
            bus.i_vp_waddr = a;
            bus.i_vp_dout  = d;
            if (exp) wq.push_back({bank, a, d});
            step();
        end
        bus.i_vp_we = 1'b0;
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (bus.o_vp_rd_rdy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_vp_rd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s: got rd_rdy=%b after %0d cycles, required 1", name,
                     bus.o_vp_rd_rdy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({bus.o_vp_rd_rdy, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_frame_vld,
             bus.o_frame_bank, bus.o_frame_err, bus.o_err_sticky, bus.o_drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b drop=%0d, required all zero",
                     bus.o_vp_rd_rdy, bus.o_frame_vld, bus.o_drop_cnt);
        end
        reset = 1'b0;
        wait_rdy("reset_first_arm");
    endtask

    task automatic test_short_frame();
        write_words(0, EXP - 1, 1'b0, 1'b1);
        bus.i_vp_rd_done = 1'b1;
        step();
        step();
        checks++;
        if ({bus.o_frame_err, bus.o_err_sticky, bus.o_drop_cnt, bus.o_frame_vld,
             bus.o_vp_rd_rdy} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL short_frame: got err=%b sticky=%b drop=%0d vld=%b rdy=%b, required 1 1 1 0 0",
                     bus.o_frame_err, bus.o_err_sticky, bus.o_drop_cnt, bus.o_frame_vld,
                     bus.o_vp_rd_rdy);
        end
        bus.i_vp_rd_done = 1'b0;
        wait_rdy("short_rearm");
        checks++;
        if (err_pulses !== 1 || bus.o_frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: got pulses=%0d vld=%b, required 1 0", err_pulses,
                     bus.o_frame_vld);
        end
    endtask

    task automatic test_single_frame();
        write_words(0, EXP, 1'b0, 1'b1);
        fq.push_back(1'b0);
        bus.i_vp_rd_done = 1'b1;
        step();
        checks++;
        if (bus.o_frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_early_vld: got vld=%b, required 0", bus.o_frame_vld);
        end
        step();
        checks++;
        if ({bus.o_frame_vld, bus.o_frame_bank, bus.o_frame_err} !== 3'b100) begin
            errors++;
            $display("FAIL single_offer: got vld=%b bank=%b err=%b, required 1 0 0",
                     bus.o_frame_vld, bus.o_frame_bank, bus.o_frame_err);
        end
        bus.i_vp_rd_done = 1'b0;
        wait_rdy("single_arm_bank1");
    endtask

    task automatic test_both_full_stalled();
        write_words(0, EXP, 1'b1, 1'b1);
        fq.push_back(1'b1);
        bus.i_vp_rd_done = 1'b1;
        step();
        step();
        bus.i_vp_rd_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_vp_we    = 1'b1;
            bus.i_vp_waddr = 16'(i);
            step();
            checks++;
            if ({bus.o_vp_rd_rdy, bus.o_frame_vld, bus.o_frame_bank} !== 3'b010) begin
                errors++;
                $display("FAIL stalled_state: got rdy=%b vld=%b bank=%b, required 0 1 0",
                         bus.o_vp_rd_rdy, bus.o_frame_vld, bus.o_frame_bank);
            end
        end
        bus.i_vp_we = 1'b0;
    endtask

    task automatic test_ml_release();
        bus.i_frame_rdy = 1'b1;
        step();
        bus.i_frame_rdy = 1'b0;
        checks++;
        if (bus.o_frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL busy_blocks_vld: got vld=%b, required 0", bus.o_frame_vld);
        end
        bus.i_ml_done = 1'b1;
        step();
        bus.i_ml_done = 1'b0;
        checks++;
        if ({bus.o_frame_vld, bus.o_frame_bank} !== 2'b11) begin
            errors++;
            $display("FAIL second_offer: got vld=%b bank=%b, required 1 1",
                     bus.o_frame_vld, bus.o_frame_bank);
        end
        wait_rdy("release_arm_bank0");
        bus.i_frame_rdy = 1'b1;
        step();
        bus.i_frame_rdy = 1'b0;
    endtask

    task automatic test_simultaneous_level();
        write_words(0, EXP, 1'b0, 1'b1);
        fq.push_back(1'b0);
        bus.i_vp_rd_done = 1'b1;
        step();
        bus.i_ml_done = 1'b1;
        step();
        bus.i_ml_done = 1'b0;
        checks++;
        if ({bus.o_frame_vld, bus.o_frame_bank} !== 2'b10) begin
            errors++;
            $display("FAIL simul_offer: got vld=%b bank=%b, required 1 0",
                     bus.o_frame_vld, bus.o_frame_bank);
        end
        wait_rdy("simul_arm_bank1");
        // rd_done stays high; the freshly armed bank must not complete again.
        for (int i = 0; i < 46; i++) begin
            write_words(i, 1, 1'b1, 1'b1);
            checks++;
            if (bus.o_vp_rd_rdy !== 1'b1) begin
                errors++;
                $display("FAIL level_done_rdy: got rdy=%b at cycle %0d, required 1",
                         bus.o_vp_rd_rdy, i);
            end
        end
        bus.i_vp_rd_done = 1'b0;
        checks++;
        if (err_pulses !== 1 || bus.o_drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL level_single_completion: got pulses=%0d drop=%0d, required 1 1",
                     err_pulses, bus.o_drop_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        write_words(46, 500 - 46, 1'b1, 1'b1);
        reset          = 1'b1;
        bus.i_vp_we    = 1'b1;
        bus.i_vp_waddr = 16'h0123;
        step();
        checks++;
        if ({bus.o_vp_rd_rdy, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_frame_vld,
             bus.o_frame_bank, bus.o_frame_err, bus.o_err_sticky, bus.o_drop_cnt} !== '0) begin
            errors++;
            $display("FAIL midfill_reset_outputs: got rdy=%b we=%b vld=%b sticky=%b drop=%0d, required all zero",
                     bus.o_vp_rd_rdy, bus.o_mem_we, bus.o_frame_vld, bus.o_err_sticky,
                     bus.o_drop_cnt);
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL midfill_writes_drained: got %0d pending, required 0", wq.size());
        end
        fq.delete();
        reset = 1'b0;
        step();
        bus.i_vp_we = 1'b0;
        wait_rdy("post_reset_arm");
        write_words(0, EXP, 1'b0, 1'b1);
        fq.push_back(1'b0);
        bus.i_vp_rd_done = 1'b1;
        step();
        step();
        bus.i_vp_rd_done = 1'b0;
        checks++;
        if ({bus.o_frame_vld, bus.o_frame_bank, bus.o_frame_err, bus.o_err_sticky,
             bus.o_drop_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL post_reset_frame: got vld=%b bank=%b err=%b sticky=%b drop=%0d, required 1 0 0 0 0",
                     bus.o_frame_vld, bus.o_frame_bank, bus.o_frame_err, bus.o_err_sticky,
                     bus.o_drop_cnt);
        end
        bus.i_frame_rdy = 1'b1;
        step();
        bus.i_frame_rdy = 1'b0;
        step();
        checks++;
        if (wq.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got writes=%0d frames=%0d, required 0 0",
                     wq.size(), fq.size());
        end
    endtask

    initial begin
        bus.i_vp_we      = 1'b0;
        bus.i_vp_waddr   = '0;
        bus.i_vp_dout    = '0;
        bus.i_vp_rd_done = 1'b0;
        bus.i_frame_rdy  = 1'b0;
        bus.i_ml_done    = 1'b0;
        test_reset();
        test_short_frame();
        test_single_frame();
        test_both_full_stalled();
        test_ml_release();
        test_simultaneous_level();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
